// File: rtl/rx_bit_timer.sv
// rx_bit_timer
// Oversampling bit timer for the UART receiver. Counts edges within a bit and
// bits within a frame, and decodes mid-bit sample strobes plus bit/frame
// completion flags from the registered state and counters. Prescale and frame
// length are captured when a frame starts, so the config bus may change freely
// while a frame is in progress.
module rx_bit_timer #(
    parameter int PWIDTH = 6,
    parameter int BWIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,            // asynchronous, active-low
    input  logic              enable,
    input  logic [PWIDTH-1:0] prescale,
    input  logic [BWIDTH-1:0] frame_bits,
    output logic [PWIDTH-1:0] edge_counter,
    output logic [BWIDTH-1:0] bit_counter,
    output logic [2:0]        sample_strobe,
    output logic              bit_done,
    output logic              frame_done,
    output logic              cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // Smallest legal configuration: P>=4 keeps all three strobes inside the
    // bit and away from edge 0; N>=2 keeps N-1 from underflowing.
    localparam logic [PWIDTH-1:0] P_MIN = PWIDTH'(4);
    localparam logic [BWIDTH-1:0] N_MIN = BWIDTH'(2);

    state_t            state_reg, state_next;
    logic [PWIDTH-1:0] edge_cnt_reg, edge_cnt_next;
    logic [BWIDTH-1:0] bit_cnt_reg, bit_cnt_next;
    logic [PWIDTH-1:0] p_reg, p_next;
    logic [BWIDTH-1:0] n_reg, n_next;

    // Derived limits from the latched configuration.
    logic [PWIDTH-1:0] p_last;
    logic [BWIDTH-1:0] n_last;
    logic [PWIDTH-1:0] mid_edge;
    logic              in_run;
    logic              at_bit_end;
    logic              cfg_bad;

    assign p_last     = p_reg - PWIDTH'(1);
    assign n_last     = n_reg - BWIDTH'(1);
    assign mid_edge   = p_reg >> 1;
    assign in_run     = (state_reg == ST_RUN);
    assign at_bit_end = (edge_cnt_reg == p_last);
    assign cfg_bad    = (prescale < P_MIN) || (frame_bits < N_MIN);

    // State, counters and latched configuration registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            edge_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            p_reg        <= '0;
            n_reg        <= '0;
        end else begin
            state_reg    <= state_next;
            edge_cnt_reg <= edge_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            p_reg        <= p_next;
            n_reg        <= n_next;
        end
    end

    // Next-state and counter update; enable low overrides everything.
    always_comb begin
        state_next    = state_reg;
        edge_cnt_next = edge_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        p_next        = p_reg;
        n_next        = n_reg;

        if (!enable) begin
            state_next    = ST_IDLE;
            edge_cnt_next = '0;
            bit_cnt_next  = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // Configuration is captured only here, at frame start.
                    p_next        = prescale;
                    n_next        = frame_bits;
                    edge_cnt_next = '0;
                    bit_cnt_next  = '0;
                    state_next    = cfg_bad ? ST_ERR : ST_RUN;
                end
                ST_RUN: begin
                    if (at_bit_end) begin
                        if (bit_cnt_reg == n_last) begin
                            // Last bit: freeze at (P-1, N-1) instead of wrapping.
                            state_next = ST_DONE;
                        end else begin
                            edge_cnt_next = '0;
                            bit_cnt_next  = bit_cnt_reg + BWIDTH'(1);
                        end
                    end else begin
                        edge_cnt_next = edge_cnt_reg + PWIDTH'(1);
                    end
                end
                ST_DONE: begin
                    // Hold final counts until enable drops; no auto-restart.
                    state_next = ST_DONE;
                end
                ST_ERR: begin
                    edge_cnt_next = '0;
                    bit_cnt_next  = '0;
                    state_next    = ST_ERR;
                end
                default: begin
                    state_next    = ST_IDLE;
                    edge_cnt_next = '0;
                    bit_cnt_next  = '0;
                end
            endcase
        end
    end

    // Strobes sit at edges M-1, M, M+1 with M = P/2 (rounded down).
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_strobe
            logic [PWIDTH-1:0] strobe_pos;
            assign strobe_pos        = mid_edge - PWIDTH'(1) + PWIDTH'(gi);
            assign sample_strobe[gi] = in_run && (edge_cnt_reg == strobe_pos);
        end
    endgenerate

    assign edge_counter = edge_cnt_reg;
    assign bit_counter  = bit_cnt_reg;
    assign bit_done     = in_run && at_bit_end;
    assign frame_done   = (state_reg == ST_DONE);
    assign cfg_err      = (state_reg == ST_ERR);

    // Counters never run past the latched limits while a frame is active.
    a_edge_in_range: assert property (@(posedge clk) disable iff (!rst)
        (state_reg == ST_RUN || state_reg == ST_DONE) |-> edge_cnt_reg <= p_last);
    a_bit_in_range: assert property (@(posedge clk) disable iff (!rst)
        (state_reg == ST_RUN || state_reg == ST_DONE) |-> bit_cnt_reg <= n_last);
    a_err_counters_zero: assert property (@(posedge clk) disable iff (!rst)
        (state_reg == ST_ERR) |-> (edge_cnt_reg == '0 && bit_cnt_reg == '0));

endmodule

// File: tb/tb_rx_bit_timer.sv
// tb_rx_bit_timer
// Directed scenarios with hand-computed expectations, then a randomized run.
// A frame-position model (elapsed RUN cycles t -> edge t%P, bit t/P) is
// compared against every DUT output on every falling clock edge.
module tb_rx_bit_timer;

    localparam int PW = 6;
    localparam int BW = 4;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;
    localparam int M_ERR  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic [PW-1:0] prescale = '0;
    logic [BW-1:0] frame_bits = '0;
    logic [PW-1:0] edge_counter;
    logic [BW-1:0] bit_counter;
    logic [2:0]    sample_strobe;
    logic          bit_done;
    logic          frame_done;
    logic          cfg_err;

    int checks = 0;
    int errors = 0;

    // Model: mode, elapsed RUN cycles in the frame, latched P and N.
    int m_mode = M_IDLE;
    int m_t    = 0;
    int m_p    = 0;
    int m_n    = 0;

    rx_bit_timer #(.PWIDTH(PW), .BWIDTH(BW)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .prescale     (prescale),
        .frame_bits   (frame_bits),
        .edge_counter (edge_counter),
        .bit_counter  (bit_counter),
        .sample_strobe(sample_strobe),
        .bit_done     (bit_done),
        .frame_done   (frame_done),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame model: the frame is a run of P*N clock cycles after start.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode <= M_IDLE;
            m_t    <= 0;
            m_p    <= 0;
            m_n    <= 0;
        end else if (!enable) begin
            m_mode <= M_IDLE;
            m_t    <= 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    m_p    <= int'(prescale);
                    m_n    <= int'(frame_bits);
                    m_t    <= 0;
                    m_mode <= (prescale < 4 || frame_bits < 2) ? M_ERR : M_RUN;
                end
                M_RUN: begin
                    if (m_t == m_p * m_n - 1) m_mode <= M_DONE;
                    else                      m_t    <= m_t + 1;
                end
                default: ;
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        int e_edge, e_bit, e_bd, e_str;
        bit active;
        active = (m_mode == M_RUN) || (m_mode == M_DONE);
        e_edge = active ? (m_t % m_p) : 0;
        e_bit  = active ? (m_t / m_p) : 0;
        e_bd   = (m_mode == M_RUN && (m_t % m_p) == m_p - 1) ? 1 : 0;
        e_str  = 0;
        if (m_mode == M_RUN)
            for (int k = 0; k < 3; k++)
                if ((m_t % m_p) == m_p / 2 - 1 + k) e_str |= (1 << k);
        chk("edge_counter", int'(edge_counter), e_edge);
        chk("bit_counter", int'(bit_counter), e_bit);
        chk("sample_strobe", int'(sample_strobe), e_str);
        chk("bit_done", int'(bit_done), e_bd);
        chk("frame_done", int'(frame_done), (m_mode == M_DONE) ? 1 : 0);
        chk("cfg_err", int'(cfg_err), (m_mode == M_ERR) ? 1 : 0);
    end

    // Start a frame from IDLE and run to frame_done, counting cycles and pulses.
    // Optionally changes prescale once the DUT reaches bit chg_bit.
    task automatic run_frame(input int p, input int n, input int chg_bit, input int chg_p,
                             output int cyc, output int bd, output int sc);
        bit seen;
        @(negedge clk);
        prescale   = PW'(p);
        frame_bits = BW'(n);
        enable     = 1'b1;
        cyc = 0; bd = 0; sc = 0; seen = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            cyc++;
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
            bd += int'(bit_done);
            sc += $countones(sample_strobe);
            if (chg_bit >= 0 && int'(bit_counter) == chg_bit) prescale = PW'(chg_p);
        end
        if (!seen) chk("frame_timeout", 0, 1);
    endtask

    task automatic wait_pos(input int b, input int e);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (int'(bit_counter) == b && int'(edge_counter) == e) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("wait_timeout", 0, 1);
    endtask

    task automatic go_idle();
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [PW-1:0] rand_p();
        if ($urandom_range(0, 9) == 0) return PW'($urandom_range(0, 63));
        return PW'($urandom_range(3, 12));
    endfunction

    initial begin
        int cyc, bd, sc;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_edge", int'(edge_counter), 0);
        chk("rst_bit", int'(bit_counter), 0);
        chk("rst_flags", int'({sample_strobe, bit_done, frame_done, cfg_err}), 0);
        rst = 1'b1;
        @(negedge clk);

        // P=8, N=10: 80 RUN cycles, DONE visible 81 cycles after enable.
        run_frame(8, 10, -1, 0, cyc, bd, sc);
        chk("p8_latency", cyc, 81);
        chk("p8_bit_done_cnt", bd, 10);
        chk("p8_strobe_cnt", sc, 30);
        repeat (3) @(negedge clk);
        chk("p8_hold_done", int'(frame_done), 1);
        chk("p8_final_edge", int'(edge_counter), 7);
        chk("p8_final_bit", int'(bit_counter), 9);
        go_idle();
        chk("p8_idle_done", int'(frame_done), 0);

        // P=5, N=2: strobes at 1,2,3; DONE after 10 RUN cycles.
        run_frame(5, 2, -1, 0, cyc, bd, sc);
        chk("p5_latency", cyc, 11);
        chk("p5_bit_done_cnt", bd, 2);
        chk("p5_strobe_cnt", sc, 6);
        chk("p5_final_edge", int'(edge_counter), 4);
        chk("p5_final_bit", int'(bit_counter), 1);
        go_idle();

        // Illegal configurations go to ERR and count nothing.
        prescale = 6'd3; frame_bits = 4'd10; enable = 1'b1;
        @(negedge clk);
        chk("err_p3_flag", int'(cfg_err), 1);
        chk("err_p3_cnt", int'(edge_counter) + int'(bit_counter) + int'(sample_strobe), 0);
        go_idle();
        chk("err_p3_clear", int'(cfg_err), 0);
        prescale = 6'd8; frame_bits = 4'd1; enable = 1'b1;
        @(negedge clk);
        chk("err_n1_flag", int'(cfg_err), 1);
        go_idle();
        chk("err_n1_clear", int'(cfg_err), 0);

        // Mid-frame prescale change is ignored; the next frame uses it.
        run_frame(16, 11, 3, 4, cyc, bd, sc);
        chk("p16_latency", cyc, 177);
        chk("p16_bit_done_cnt", bd, 11);
        go_idle();
        run_frame(4, 11, -1, 0, cyc, bd, sc);
        chk("p4_latency", cyc, 45);
        go_idle();

        // Abort at bit 5 edge 6, then restart from zero.
        prescale = 6'd8; frame_bits = 4'd10; enable = 1'b1;
        wait_pos(5, 6);
        enable = 1'b0;
        @(negedge clk);
        chk("abort_cnt", int'(edge_counter) + int'(bit_counter), 0);
        chk("abort_flags", int'({sample_strobe, bit_done, frame_done, cfg_err}), 0);
        enable = 1'b1;
        @(negedge clk);
        chk("restart_edge0", int'(edge_counter), 0);
        @(negedge clk);
        chk("restart_edge1", int'(edge_counter), 1);
        go_idle();

        // Asynchronous reset in the middle of bit 4.
        prescale = 6'd8; frame_bits = 4'd10; enable = 1'b1;
        wait_pos(4, 2);
        #2 rst = 1'b0;
        #1;
        chk("arst_edge", int'(edge_counter), 0);
        chk("arst_bit", int'(bit_counter), 0);
        chk("arst_strobe", int'(sample_strobe), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("arst_run_edge0", int'(edge_counter), 0);
        @(negedge clk);
        chk("arst_run_edge1", int'(edge_counter), 1);
        go_idle();

        // Randomized traffic: random configs, mid-frame config changes, aborts.
        prescale   = rand_p();
        frame_bits = BW'($urandom_range(1, 15));
        enable     = 1'b1;
        for (int c = 0; c < 8000; c++) begin
            @(negedge clk);
            if (!enable) begin
                enable = 1'b1;
                prescale   = rand_p();
                frame_bits = BW'($urandom_range(0, 15));
            end else if (m_mode == M_DONE || m_mode == M_ERR) begin
                if ($urandom_range(0, 3) == 0) enable = 1'b0;
            end else if ($urandom_range(0, 199) == 0) begin
                enable = 1'b0;
            end
            if ($urandom_range(0, 19) == 0) prescale = rand_p();
            if ($urandom_range(0, 19) == 0) frame_bits = BW'($urandom_range(0, 15));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
